// File: rtl/rmsk_pkg.sv
// Shared types and the per-channel byte-mask rule for the rmsk_pipe block.
package rmsk_pkg;

  localparam int MAXB    = 64;
  localparam int MAXIDXW = 6;
  localparam int MAXCW   = MAXIDXW + 1;

  function automatic int idx_w(input int nbytes);
    return $clog2(nbytes);
  endfunction

  typedef struct packed {
    logic [MAXIDXW-1:0] strt;
    logic [MAXIDXW-1:0] endb;
    logic               wrap;
  } rmsk_req_t;

  typedef struct packed {
    logic [MAXB-1:0]  mask;
    logic [MAXCW-1:0] cnt;
    logic             err;
  } rmsk_res_t;

  // Computed at the widest supported word; callers slice down to their NBYTES.
  function automatic rmsk_res_t calc_mask(input int nbytes, input rmsk_req_t req);
    rmsk_res_t res;
    int        s;
    int        e;
    res = '0;
    s   = int'(req.strt);
    e   = int'(req.endb);
    if (s <= e) begin
      for (int i = 0; i < MAXB; i++) res.mask[i] = (i >= s) && (i <= e);
      res.cnt = MAXCW'(e - s + 1);
    end else if (req.wrap) begin
      for (int i = 0; i < MAXB; i++) res.mask[i] = ((i >= s) && (i < nbytes)) || (i <= e);
      res.cnt = MAXCW'(nbytes - s + e + 1);
    end else begin
      res.err = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rmsk_pipe_if.sv
// Request/result handshake bundle between request decode and the write-data path.
interface rmsk_pipe_if import rmsk_pkg::*; #(
  parameter int NCHAN  = 3,
  parameter int NBYTES = 8,
  parameter int ERRW   = 16,
  localparam int IDXW  = idx_w(NBYTES)
);

  logic                        in_valid;
  logic                        in_ready;
  logic                        wrap_en;
  logic [NCHAN*IDXW-1:0]       strtbyte;
  logic [NCHAN*IDXW-1:0]       endbyte;
  logic                        out_valid;
  logic                        out_ready;
  logic [NCHAN*NBYTES-1:0]     rmsk;
  logic [NCHAN*(IDXW+1)-1:0]   rcnt;
  logic [NCHAN-1:0]            rerr;
  logic [ERRW-1:0]             err_cnt;

  modport master (
    output in_valid, wrap_en, strtbyte, endbyte, out_ready,
    input  in_ready, out_valid, rmsk, rcnt, rerr, err_cnt
  );

  modport slave (
    input  in_valid, wrap_en, strtbyte, endbyte, out_ready,
    output in_ready, out_valid, rmsk, rcnt, rerr, err_cnt
  );

endinterface

// File: rtl/rmsk_lane.sv
// Combinational mask, count and error for one channel.
module rmsk_lane import rmsk_pkg::*; #(
  parameter int NBYTES = 8,
  localparam int IDXW  = idx_w(NBYTES)
) (
  input  rmsk_req_t         i_req,
  output logic [NBYTES-1:0] o_mask,
  output logic [IDXW:0]     o_cnt,
  output logic              o_err
);

  rmsk_res_t w_res;
  logic      w_unused;

  assign w_res  = calc_mask(NBYTES, i_req);
  assign o_mask = w_res.mask[NBYTES-1:0];
  assign o_cnt  = w_res.cnt[IDXW:0];
  assign o_err  = w_res.err;

  // Bits above NBYTES and the top count bits are always zero for narrow words.
  assign w_unused = ^{w_res.mask, w_res.cnt};

endmodule

// File: rtl/rmsk_pipe.sv
// Two-stage valid/ready pipeline producing per-channel byte masks, counts and errors.
module rmsk_pipe import rmsk_pkg::*; #(
  parameter int NCHAN  = 3,
  parameter int NBYTES = 8,
  parameter int ERRW   = 16,
  localparam int IDXW  = idx_w(NBYTES),
  localparam int CW    = IDXW + 1,
  localparam int EW1   = ERRW + 1
) (
  input  logic       clk,
  input  logic       reset,
  rmsk_pipe_if.slave io_bus
);

  rmsk_req_t               r_s1_req [NCHAN];
  logic                    r_s1_valid;
  logic                    r_out_valid;
  logic [NCHAN*NBYTES-1:0] r_rmsk;
  logic [NCHAN*CW-1:0]     r_rcnt;
  logic [NCHAN-1:0]        r_rerr;
  logic [ERRW-1:0]         r_err_cnt;

  logic                    w_advance;
  logic                    w_in_ready;
  logic [NBYTES-1:0]       w_mask [NCHAN];
  logic [CW-1:0]           w_cnt  [NCHAN];
  logic [NCHAN-1:0]        w_err;
  logic [ERRW:0]           w_pop;
  logic [ERRW:0]           w_sum;

  assign w_advance  = !r_out_valid || io_bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_advance;

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.rmsk      = r_rmsk;
  assign io_bus.rcnt      = r_rcnt;
  assign io_bus.rerr      = r_rerr;
  assign io_bus.err_cnt   = r_err_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
    end else if (w_in_ready) begin
      r_s1_valid <= io_bus.in_valid;
      if (io_bus.in_valid) begin
        for (int c = 0; c < NCHAN; c++) begin
          r_s1_req[c] <= '{strt: MAXIDXW'(io_bus.strtbyte[c*IDXW +: IDXW]),
                           endb: MAXIDXW'(io_bus.endbyte[c*IDXW +: IDXW]),
                           wrap: io_bus.wrap_en};
        end
      end
    end
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_lane
    rmsk_lane #(.NBYTES(NBYTES)) u_lane (
      .i_req  (r_s1_req[c]),
      .o_mask (w_mask[c]),
      .o_cnt  (w_cnt[c]),
      .o_err  (w_err[c])
    );
  end

  // Output register only reloads on advance, so a stalled result stays put.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_rmsk      <= '0;
      r_rcnt      <= '0;
      r_rerr      <= '0;
    end else if (w_advance) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        for (int c = 0; c < NCHAN; c++) begin
          r_rmsk[c*NBYTES +: NBYTES] <= w_mask[c];
          r_rcnt[c*CW +: CW]         <= w_cnt[c];
        end
        r_rerr <= w_err;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int c = 0; c < NCHAN; c++) w_pop = w_pop + EW1'(r_rerr[c]);
    w_sum = {1'b0, r_err_cnt} + w_pop;
  end

  // A carry out of the counter width means we crossed the ceiling: pin at all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (r_out_valid && io_bus.out_ready) begin
      r_err_cnt <= w_sum[ERRW] ? {ERRW{1'b1}} : w_sum[ERRW-1:0];
    end
  end

endmodule
